// File: rtl/hc_scan_mux_pkg.sv
// Shared encodings for the scanning channel selector.
// Mode and state values are fixed so other blocks can decode them directly.
package hc_scan_mux_pkg;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic [1:0] {
        ST_DIS  = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Target state for this edge, decided only by the enable and mode pins.
    function automatic state_t next_state(input logic enn, input logic mode);
        if (enn)
            return ST_DIS;
        else if (mode == MODE_SCAN)
            return ST_SCAN;
        else
            return ST_MAN;
    endfunction

endpackage

// File: rtl/hc_mux_sel.sv
// N:1 selector in AND-OR form: each channel is gated by its decoded select
// line and the gated channels are ORed together.
module hc_mux_sel #(
    parameter int WIDTH = 2,
    parameter int NSEL  = 2
) (
    input  logic [WIDTH*(2**NSEL)-1:0] din,
    input  logic [NSEL-1:0]            sel,
    output logic [WIDTH-1:0]           dout
);

    localparam int NCH = 2 ** NSEL;

    always_comb begin
        dout = '0;
        for (int i = 0; i < NCH; i++) begin
            dout = dout | (din[i*WIDTH +: WIDTH] & {WIDTH{sel == NSEL'(i)}});
        end
    end

endmodule

// File: rtl/hc_scan_mux.sv
// Registered channel selector with manual select and an automatic scan mode
// that dwells a programmable number of cycles on each channel.
module hc_scan_mux
    import hc_scan_mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int NSEL  = 2,
    parameter int DWELL = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH*(2**NSEL)-1:0] IN,
    input  logic                       ENn,
    input  logic                       MODE,
    input  logic [NSEL-1:0]            SEL,
    output logic [WIDTH-1:0]           OUT,
    output logic [NSEL-1:0]            CUR_SEL,
    output logic                       VALID,
    output logic                       WRAP
);

    localparam int NCH = 2 ** NSEL;
    localparam int DW  = $clog2(DWELL) + 1;

    generate
        if (DWELL < 1) begin : g_bad_dwell
            $error("hc_scan_mux: DWELL must be at least 1");
        end
    endgenerate

    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [NSEL-1:0] PTR_LAST   = NSEL'(NCH - 1);

    state_t          state;
    state_t          nxt;
    logic            last_scan;
    logic [NSEL-1:0] ptr;
    logic [DW-1:0]   dwell_cnt;
    logic [NSEL-1:0] mux_sel;
    logic [WIDTH-1:0] mux_data;
    logic            scan_restart;

    assign nxt     = next_state(ENn, MODE);
    assign mux_sel = (MODE == MODE_SCAN) ? ptr : SEL;

    // A scan entered after manual use starts over; after a pure disable it resumes.
    assign scan_restart = (state == ST_MAN) || ((state == ST_DIS) && !last_scan);

    hc_mux_sel #(
        .WIDTH (WIDTH),
        .NSEL  (NSEL)
    ) u_mux_sel (
        .din  (IN),
        .sel  (mux_sel),
        .dout (mux_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_DIS;
            last_scan <= 1'b1;
            ptr       <= '0;
            dwell_cnt <= '0;
            OUT       <= '0;
            CUR_SEL   <= '0;
            VALID     <= 1'b0;
            WRAP      <= 1'b0;
        end else begin
            state <= nxt;
            unique case (nxt)
                ST_MAN: begin
                    last_scan <= 1'b0;
                    OUT       <= mux_data;
                    CUR_SEL   <= SEL;
                    VALID     <= 1'b1;
                    WRAP      <= 1'b0;
                end
                ST_SCAN: begin
                    last_scan <= 1'b1;
                    if (scan_restart) begin
                        ptr       <= '0;
                        dwell_cnt <= '0;
                        VALID     <= 1'b0;
                        WRAP      <= 1'b0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        OUT       <= mux_data;
                        CUR_SEL   <= ptr;
                        VALID     <= 1'b1;
                        WRAP      <= (ptr == PTR_LAST);
                        ptr       <= ptr + 1'b1;
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                        VALID     <= 1'b0;
                        WRAP      <= 1'b0;
                    end
                end
                default: begin
                    OUT   <= '0;
                    VALID <= 1'b0;
                    WRAP  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hc_scan_mux.md
Name: hc_scan_mux

Overview:
Parametrised, registered successor to the dual 4:1 selector chip model in the 4-bit discrete-logic environment.
- Selects one of 2^NSEL input channels, each WIDTH bits wide, onto a registered output.
- Manual mode: the channel comes from SEL.
- Scan mode: an internal pointer walks all channels with a programmable dwell time.
- Used for time-multiplexed display/bus sampling beside the 74-series models.

Parameters:
WIDTH, 2, bits per channel (number of mux sections).
NSEL, 2, select width; channel count NCH = 2^NSEL.
DWELL, 1, clock cycles spent on each channel in scan mode (>=1).

Ports:
CLK  input  1  single clock; all state updates on rising edge.
RST  input  1  reset is synchronous and active-high.
IN  input  WIDTH*NCH  flattened inputs, channel-major: channel i occupies IN[i*WIDTH +: WIDTH].
ENn  input  1  active-low enable; high forces output to zero and freezes scan state.
MODE  input  1  0 = manual select, 1 = auto scan.
SEL  input  NSEL  channel select in manual mode; ignored in scan mode.
OUT  output  WIDTH  registered selected channel.
CUR_SEL  output  NSEL  channel index that OUT currently holds.
VALID  output  1  high for one cycle when OUT/CUR_SEL were updated with a fresh sample.
WRAP  output  1  one-cycle pulse, coincident with VALID, when the sample came from channel NCH-1 in scan mode.

Behaviour:
- Reset (RST=1 at edge), dominant over everything: OUT=0, CUR_SEL=0, VALID=0, WRAP=0, ptr=0, dwell_cnt=0, state=DIS.
- States (2-bit): DIS, MAN, SCAN. Next state is evaluated every cycle:
  - ENn=1 -> DIS
  - ENn=0 and MODE=0 -> MAN
  - ENn=0 and MODE=1 -> SCAN
- DIS:
  - OUT<=0, VALID<=0, WRAP<=0.
  - CUR_SEL, ptr and dwell_cnt hold their values.
- MAN:
  - Every cycle: OUT<=IN[SEL], CUR_SEL<=SEL, VALID<=1, WRAP<=0.
  - Latency 1 cycle from SEL/IN change to OUT.
  - ptr and dwell_cnt are untouched.
- SCAN:
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt==DWELL-1: OUT<=IN[ptr], CUR_SEL<=ptr, VALID<=1, WRAP<=(ptr==NCH-1), ptr<=ptr+1 (wraps modulo NCH), dwell_cnt<=0.
  - Otherwise: dwell_cnt++, VALID<=0, WRAP<=0, OUT holds.
  - DWELL=1 gives one sample per cycle: VALID constant high, WRAP every NCH cycles.
- Entering SCAN from MAN, or from DIS when the previous active state was MAN: ptr<=0, dwell_cnt<=0 on that transition cycle. The first sample is channel 0 after DWELL cycles.
- DIS->SCAN with the previous active state SCAN: resume from the frozen ptr/dwell_cnt. A track bit records the last active mode.
- Leaving SCAN for MAN mid-dwell: the partial dwell is discarded, and the next cycle behaves as MAN.
- ENn asserted mid-dwell: OUT goes to 0 next edge and the dwell is frozen, not restarted.
- IN sampled only at the capture edge; changes between captures do not affect OUT in SCAN.
- Width rules:
  - ptr is NSEL bits, natural wrap.
  - dwell_cnt is $clog2(DWELL)+1 bits.
  - DWELL<1 is illegal; flag with an elaboration-time check.

Decomposition:
- Shared parameter header:
  - mode encodings: MODE_MAN=1'b0, MODE_SCAN=1'b1.
  - state encodings: ST_DIS=2'd0, ST_MAN=2'd1, ST_SCAN=2'd2.
- One combinational sub-module, hc_mux_sel: parametrised WIDTH/NSEL N:1 selector (AND-OR form, matching the chip-model style). Instantiated once with select = MODE ? ptr : SEL.
- FSM, dwell counter and output registers live in hc_scan_mux.

Test Plan:
1. WIDTH=2, NSEL=2. RST high 2 cycles with ENn=0, MODE=1 -> OUT=0, CUR_SEL=0, VALID=0, WRAP=0 throughout reset.
2. Manual, ENn=0, MODE=0, IN=8'b11_10_01_00, SEL stepped 0,1,2,3 on consecutive cycles -> OUT=00,01,10,11 one cycle later each, CUR_SEL follows, VALID=1 steady.
3. Scan, DWELL=1, same IN -> OUT sequence 00,01,10,11,00,... every cycle. WRAP=1 only with OUT=11/CUR_SEL=3, i.e. every 4th cycle.
4. Scan, DWELL=3 -> VALID pulses every 3rd cycle. CUR_SEL 0,1,2,3,0. IN changes between pulses are not reflected until the next pulse.
5. Scan, DWELL=3, ENn=1 for 5 cycles at ptr=2, dwell_cnt=1 -> OUT=0, VALID=0 during disable. After ENn=0, channel 2 is captured 2 cycles later; WRAP follows after channel 3.
6. Scan at ptr=2, switch MODE=0 for 1 cycle with SEL=1, then back to MODE=1 -> one MAN sample of channel 1. Scan then restarts at channel 0 after DWELL cycles.
